// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage and the multi-cycle data memory responder.
// The pipeline side uses the master modport, the responder uses the slave modport.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Pipeline (MEM stage) view
    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  stall,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    // Memory responder view
    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output stall,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder for the MEM stage.
// Accepts one load/store in IDLE, waits LATENCY cycles, performs the access on the last
// WAIT edge and pulses rsp_valid for one cycle in RESP. The pipeline is stalled from the
// request cycle until RESP so it advances in the same cycle the response is seen.
// Optional feature: define DMEM_ERR_EN to flag out-of-range or misaligned addresses
// (no write, zero read data, rsp_err=1); otherwise the word index wraps and rsp_err is 0.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q,     state_d;
    logic [CNT_W-1:0]    count_q,     count_d;
    logic                req_we_q,    req_we_d;
    logic [ADDR_W-1:0]   req_addr_q,  req_addr_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;

    logic [IDX_W-1:0]    idx_c;
    logic                addr_err_c;
    logic                mem_we_c;

    logic [DATA_W-1:0]   mem [DEPTH_WORDS];

    // Word index and address check on the latched request
    always_comb begin
        idx_c = req_addr_q[2 +: IDX_W];
`ifdef DMEM_ERR_EN
        addr_err_c = (req_addr_q >= ADDR_W'(4 * DEPTH_WORDS)) || (req_addr_q[1:0] != 2'b00);
`else
        addr_err_c = 1'b0;
`endif
    end

`ifndef DMEM_ERR_EN
    // Upper and byte-offset address bits play no part when indices wrap
    logic unused_addr_bits_c;
    assign unused_addr_bits_c = ^{req_addr_q[ADDR_W-1:IDX_W+2], req_addr_q[1:0]};
`endif

    // Next-state, request capture and access logic
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    req_we_d    = bus.req_we;
                    req_addr_d  = bus.req_addr;
                    req_wdata_d = bus.req_wdata;
                    count_d     = CNT_W'(LATENCY - 1);
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    state_d = ST_RESP;
                    if (addr_err_c) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else if (req_we_q) begin
                        mem_we_c    = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                    end else begin
                        rsp_rdata_d = mem[idx_c];
                        rsp_err_d   = 1'b0;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request and response registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage array; intentionally not reset so contents survive a pipeline reset
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem[idx_c] <= req_wdata_q;
        end
    end

    // Handshake outputs decoded from the state register
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.stall     = ((state_q == ST_IDLE) && bus.req_valid) || (state_q == ST_WAIT);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of single transactions with a response scoreboard,
// plus cycle-accurate sequences for stall timing, back-to-back requests, reset in WAIT
// and a LATENCY=1 instance.
module tb_dmem_responder;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    dmem_responder_if bus0();
    dmem_responder_if bus1();

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.slave)
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
    } sb_t;

    sb_t  sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[11];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkvec(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                   input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // Scoreboard: every response of the LATENCY=2 instance must match the oldest expectation
    always @(negedge clock) begin
        sb_t e;
        if (!reset && bus0.rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                check32("rsp_rdata", bus0.rsp_rdata, e.rdata);
                check32("rsp_err", 32'(bus0.rsp_err), 32'(e.err));
                check32("rsp_latency", 32'(cyc - e.acc_cyc), 32'd3);
            end
        end
    end

    task automatic drive0(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus0.req_we    = we;
        bus0.req_addr  = addr;
        bus0.req_wdata = wdata;
        bus0.req_valid = 1'b1;
    endtask

    // Wait for the accepting cycle, then record the expected response
    task automatic wait_accept(input logic [31:0] r, input logic e, output int acc);
        int k = 0;
        acc = -1;
        do begin
            @(negedge clock);
            k++;
        end while (!(bus0.req_ready === 1'b1 && bus0.req_valid === 1'b1) && k < 50);
        if (bus0.req_ready === 1'b1) begin
            acc = cyc;
            sb_q.push_back('{rdata: r, err: e, acc_cyc: cyc});
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready=%b expected 1", bus0.req_ready);
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: got %0d pending responses expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // One transaction; request fields are scrambled after accept to prove they are latched
    task automatic apply_one(input vec_t v);
        int acc;
        @(posedge clock); #1;
        drive0(v.we, v.addr, v.wdata);
        wait_accept(v.exp_rdata, v.exp_err, acc);
        @(posedge clock); #1;
        bus0.req_valid = 1'b0;
        bus0.req_we    = ~v.we;
        bus0.req_addr  = $urandom;
        bus0.req_wdata = $urandom;
        wait_drain();
    endtask

    // Cycle-accurate transaction on the LATENCY=1 instance
    task automatic l1_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata);
        @(posedge clock); #1;
        bus1.req_we    = we;
        bus1.req_addr  = addr;
        bus1.req_wdata = wdata;
        bus1.req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check32("l1_stall", 32'(bus1.stall), 32'(k <= 1));
            check32("l1_rsp_valid", 32'(bus1.rsp_valid), 32'(k == 2));
            if (k == 0) check32("l1_req_ready", 32'(bus1.req_ready), 32'd1);
            if (k == 2) begin
                check32("l1_rsp_rdata", bus1.rsp_rdata, exp_rdata);
                check32("l1_rsp_err", 32'(bus1.rsp_err), 32'd0);
            end
            if (k == 0) begin
                @(posedge clock); #1;
                bus1.req_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected $finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        vec_t seq3[3];

        vecs[0] = mkvec(1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
        vecs[1] = mkvec(1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        vecs[2] = mkvec(1'b1, 32'h00,  32'h11111111, 32'h0,        1'b0);
        vecs[3] = mkvec(1'b1, 32'h20,  32'h0BADF00D, 32'h0,        1'b0);
        vecs[4] = mkvec(1'b0, 32'h20,  32'h0,        32'h0BADF00D, 1'b0);
        vecs[5] = mkvec(1'b1, 32'hFC,  32'h5A5A5A5A, 32'h0,        1'b0);
        vecs[6] = mkvec(1'b0, 32'hFC,  32'h0,        32'h5A5A5A5A, 1'b0);
        vecs[7] = mkvec(1'b0, 32'h00,  32'h0,        32'h11111111, 1'b0);
`ifdef DMEM_ERR_EN
        vecs[8]  = mkvec(1'b1, 32'h100, 32'h12345678, 32'h0,        1'b1);
        vecs[9]  = mkvec(1'b0, 32'h000, 32'h0,        32'h11111111, 1'b0);
        vecs[10] = mkvec(1'b0, 32'h013, 32'h0,        32'h0,        1'b1);
`else
        vecs[8]  = mkvec(1'b1, 32'h100, 32'h12345678, 32'h0,        1'b0);
        vecs[9]  = mkvec(1'b0, 32'h000, 32'h0,        32'h12345678, 1'b0);
        vecs[10] = mkvec(1'b0, 32'h013, 32'h0,        32'hDEADBEEF, 1'b0);
`endif
        seq3[0] = mkvec(1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        seq3[1] = mkvec(1'b1, 32'h10, 32'h01234567, 32'h0,        1'b0);
        seq3[2] = mkvec(1'b0, 32'h10, 32'h0,        32'h01234567, 1'b0);

        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check32("rst_req_ready", 32'(bus0.req_ready), 32'd1);
        check32("rst_stall", 32'(bus0.stall), 32'd0);
        check32("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check32("rst_rsp_rdata", bus0.rsp_rdata, 32'd0);
        check32("rst_rsp_err", 32'(bus0.rsp_err), 32'd0);
        check32("rst1_req_ready", 32'(bus1.req_ready), 32'd1);
        check32("rst1_rsp_rdata", bus1.rsp_rdata, 32'd0);

        // Stall/ready/rsp_valid timing of a store, cycles 0..4 after presenting it
        @(posedge clock); #1;
        drive0(1'b1, 32'h44, 32'h600DCAFE);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (k == 0) sb_q.push_back('{rdata: 32'h0, err: 1'b0, acc_cyc: cyc});
            check32("t_stall", 32'(bus0.stall), 32'(k <= 2));
            check32("t_rsp_valid", 32'(bus0.rsp_valid), 32'(k == 3));
            check32("t_req_ready", 32'(bus0.req_ready), 32'(k == 0 || k == 4));
            if (k == 0) begin
                @(posedge clock); #1;
                bus0.req_valid = 1'b0;
            end
        end
        wait_drain();
        apply_one(mkvec(1'b0, 32'h44, 32'h0, 32'h600DCAFE, 1'b0));

        // Vector table
        for (int i = 0; i < 11; i++) apply_one(vecs[i]);

        // req_valid held high across load/store/load: one accept per IDLE, 4 cycles apart
        prev = 0;
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            drive0(seq3[i].we, seq3[i].addr, seq3[i].wdata);
            wait_accept(seq3[i].exp_rdata, seq3[i].exp_err, acc);
            if (i > 0) check32("accept_spacing", 32'(acc - prev), 32'd4);
            prev = acc;
            @(posedge clock); #1;
        end
        bus0.req_valid = 1'b0;
        wait_drain();

        // Reset during WAIT drops the pending store
        apply_one(mkvec(1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0));
        @(posedge clock); #1;
        drive0(1'b1, 32'h20, 32'hAAAA5555);
        @(negedge clock);
        check32("rw_accept_ready", 32'(bus0.req_ready), 32'd1);
        @(posedge clock); #1;
        bus0.req_valid = 1'b0;
        @(negedge clock);
        check32("rw_wait_stall", 32'(bus0.stall), 32'd1);
        #1 reset = 1'b1;
        #1;
        check32("rw_req_ready", 32'(bus0.req_ready), 32'd1);
        check32("rw_stall", 32'(bus0.stall), 32'd0);
        check32("rw_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check32("rw_rsp_rdata", bus0.rsp_rdata, 32'd0);
        check32("rw_rsp_err", 32'(bus0.rsp_err), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        apply_one(mkvec(1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0));

        // LATENCY=1 instance
        l1_txn(1'b1, 32'h08, 32'hCAFEF00D, 32'h0);
        l1_txn(1'b0, 32'h08, 32'h0,        32'hCAFEF00D);

        // No stray responses afterwards
        repeat (6) @(negedge clock);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
